// File: rtl/ring_osc_meas_ctrl_pkg.sv
// Shared FSM state encoding and default widths for the ring-oscillator
// measurement controller and its readout logic.
package ring_osc_meas_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WARMUP  = 3'd1,
      ST_MEASURE = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DONE    = 3'd4
   } meas_state_e;

   localparam int DEF_CNT_W = 16;
   localparam int DEF_WIN_W = 16;

endpackage

// File: rtl/ring_osc_meas_ctrl_ro_edge_sync.sv
// Multi-flop synchroniser for an asynchronous oscillator input followed by
// a single-cycle rising-edge pulse generator.
module ro_edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic ro_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              last_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], ro_i};
         last_q <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enable, warm-up, counted window,
// drain, report. RING_OSC_MEAS_ACCUM_EN averages 2^ACC_LOG2 passes per start.
module ring_osc_meas_ctrl
   import ring_osc_meas_ctrl_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int WIN_W       = DEF_WIN_W,
   parameter int WARMUP_CYC  = 8,
   parameter int SYNC_STAGES = 2
`ifdef RING_OSC_MEAS_ACCUM_EN
   ,
   parameter int ACC_LOG2    = 2
`endif
) (
   input  logic             CLK_i,
   input  logic             RSTn_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [WIN_W-1:0] window_i,
   input  logic             ro_i,
   output logic             ro_en_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] count_o,
   output logic             valid_o,
   output logic             overflow_o
);

   localparam int WU_W  = $clog2(WARMUP_CYC + SYNC_STAGES + 1);
   localparam int TMR_W = (WIN_W > WU_W) ? WIN_W : WU_W;

   meas_state_e      state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             ro_en_q, ro_en_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             rise;

`ifdef RING_OSC_MEAS_ACCUM_EN
   localparam int ACC_W = CNT_W + ACC_LOG2;

   logic [ACC_LOG2-1:0] pass_q, pass_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACC_W-1:0]    acc_sum;

   assign acc_sum = acc_q + ACC_W'(cnt_q);
`endif

   ro_edge_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i  (CLK_i),
      .rst_ni (RSTn_i),
      .ro_i   (ro_i),
      .rise_o (rise)
   );

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      count_d = count_q;
      ovf_d   = ovf_q;
`ifdef RING_OSC_MEAS_ACCUM_EN
      pass_d  = pass_q;
      acc_d   = acc_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start_i && !abort_i) begin
               win_d = window_i;
               cnt_d = '0;
               sat_d = 1'b0;
`ifdef RING_OSC_MEAS_ACCUM_EN
               pass_d = '0;
               acc_d  = '0;
`endif
               if (window_i == '0) begin
                  state_d = ST_DONE;
                  count_d = '0;
                  ovf_d   = 1'b0;
               end else begin
                  state_d = ST_WARMUP;
                  tmr_d   = TMR_W'(WARMUP_CYC - 1);
               end
            end
         end
         ST_WARMUP: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (tmr_q == '0) begin
               state_d = ST_MEASURE;
               tmr_d   = TMR_W'(win_q) - TMR_W'(1);
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ST_MEASURE: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else begin
               if (rise) begin
                  if (&cnt_q) sat_d = 1'b1;
                  else        cnt_d = cnt_q + CNT_W'(1);
               end
               if (tmr_q == '0) begin
                  state_d = ST_DRAIN;
                  tmr_d   = TMR_W'(SYNC_STAGES - 1);
               end else begin
                  tmr_d = tmr_q - TMR_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (tmr_q != '0) begin
               tmr_d = tmr_q - TMR_W'(1);
            end else begin
`ifdef RING_OSC_MEAS_ACCUM_EN
               // sat_q stays sticky across passes so any saturated pass flags
               if (&pass_q) begin
                  state_d = ST_DONE;
                  count_d = CNT_W'(acc_sum >> ACC_LOG2);
                  ovf_d   = sat_q;
               end else begin
                  state_d = ST_WARMUP;
                  tmr_d   = TMR_W'(WARMUP_CYC - 1);
                  pass_d  = pass_q + ACC_LOG2'(1);
                  acc_d   = acc_sum;
                  cnt_d   = '0;
               end
`else
               state_d = ST_DONE;
               count_d = cnt_q;
               ovf_d   = sat_q;
`endif
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign ro_en_d = (state_d == ST_WARMUP) || (state_d == ST_MEASURE);

   always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         win_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         ro_en_q <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         ro_en_q <= ro_en_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef RING_OSC_MEAS_ACCUM_EN
   always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
         pass_q <= '0;
         acc_q  <= '0;
      end else begin
         pass_q <= pass_d;
         acc_q  <= acc_d;
      end
   end
`endif

   assign ro_en_o    = ro_en_q;
   assign busy_o     = (state_q != ST_IDLE);
   assign valid_o    = (state_q == ST_DONE);
   assign count_o    = count_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Directed bench: default instance plus a CNT_W=4 instance for saturation,
// each driven by a behavioural ring oscillator gated by ro_en_o.
module tb_ring_osc_meas_ctrl;

   localparam int ST = 2;
`ifdef RING_OSC_MEAS_ACCUM_EN
   localparam int PASSES = 4;
`else
   localparam int PASSES = 1;
`endif

   logic        clk, rst_n;
   logic        start, abort, ro;
   logic [15:0] window;
   logic        ro_en, busy, valid, ovf;
   logic [15:0] count;

   logic        start4, abort4, ro4;
   logic [15:0] win4;
   logic        ro_en4, busy4, valid4, ovf4;
   logic [3:0]  count4;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int win;
      int lat;
      int cnt;
   } vec_t;
   vec_t vecs[5];

   ring_osc_meas_ctrl dut (
      .CLK_i      (clk),
      .RSTn_i     (rst_n),
      .start_i    (start),
      .abort_i    (abort),
      .window_i   (window),
      .ro_i       (ro),
      .ro_en_o    (ro_en),
      .busy_o     (busy),
      .count_o    (count),
      .valid_o    (valid),
      .overflow_o (ovf)
   );

   ring_osc_meas_ctrl #(.CNT_W(4)) dut4 (
      .CLK_i      (clk),
      .RSTn_i     (rst_n),
      .start_i    (start4),
      .abort_i    (abort4),
      .window_i   (win4),
      .ro_i       (ro4),
      .ro_en_o    (ro_en4),
      .busy_o     (busy4),
      .count_o    (count4),
      .valid_o    (valid4),
      .overflow_o (ovf4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // oscillator models: toggle every 5 (resp. 2) cycles while enabled
   initial begin
      int c = 0;
      ro = 1'b0;
      forever begin
         @(negedge clk);
         if (ro_en !== 1'b1) begin
            ro = 1'b0;
            c  = 0;
         end else begin
            c++;
            if (c == 5) begin
               ro = ~ro;
               c  = 0;
            end
         end
      end
   end

   initial begin
      int c = 0;
      ro4 = 1'b0;
      forever begin
         @(negedge clk);
         if (ro_en4 !== 1'b1) begin
            ro4 = 1'b0;
            c   = 0;
         end else begin
            c++;
            if (c == 2) begin
               ro4 = ~ro4;
               c   = 0;
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   function automatic int exp_lat(input int l);
      return (l == 1) ? 1 : 1 + PASSES * (l - 1);
   endfunction

   task automatic run_meas(input int win, output int lat, output int nv,
                           output int cnt, output int ov,
                           output int saw_en, output int busy1);
      lat = -1; nv = 0; cnt = -1; ov = -1; saw_en = 0;
      @(negedge clk);
      window = 16'(win);
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      busy1 = int'(busy);
      for (int k = 1; k <= 3000; k++) begin
         @(negedge clk);
         if (ro_en) saw_en = 1;
         if (valid) begin
            nv++;
            if (lat < 0) begin
               lat = k;
               cnt = int'(count);
               ov  = int'(ovf);
            end
         end
         if (!busy) break;
      end
   endtask

   task automatic run4(input int win, output int lat, output int nv,
                       output int cnt, output int ov);
      lat = -1; nv = 0; cnt = -1; ov = -1;
      @(negedge clk);
      win4   = 16'(win);
      start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      for (int k = 1; k <= 4000; k++) begin
         @(negedge clk);
         if (valid4) begin
            nv++;
            if (lat < 0) begin
               lat = k;
               cnt = int'(count4);
               ov  = int'(ovf4);
            end
         end
         if (!busy4) break;
      end
   endtask

   initial begin
      int lat, nv, cnt, ov, en, b1;
      vecs[0] = '{win: 0,   lat: 1,   cnt: 0};
      vecs[1] = '{win: 1,   lat: 12,  cnt: 0};
      vecs[2] = '{win: 10,  lat: 21,  cnt: 1};
      vecs[3] = '{win: 37,  lat: 48,  cnt: 3};
      vecs[4] = '{win: 100, lat: 111, cnt: 10};

      rst_n = 1'b0;
      start = 1'b0; abort = 1'b0; window = '0;
      start4 = 1'b0; abort4 = 1'b0; win4 = '0;
      repeat (3) @(negedge clk);
      chk("rst ro_en", int'(ro_en), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst count", int'(count), 0);
      chk("rst valid", int'(valid), 0);
      chk("rst ovf", int'(ovf), 0);
      chk("rst count4", int'(count4), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) begin
         run_meas(vecs[i].win, lat, nv, cnt, ov, en, b1);
         chk($sformatf("v%0d busy", i), b1, 1);
         chk($sformatf("v%0d latency", i), lat, exp_lat(vecs[i].lat));
         chk($sformatf("v%0d nvalid", i), nv, 1);
         chk($sformatf("v%0d count", i), cnt, vecs[i].cnt);
         chk($sformatf("v%0d ovf", i), ov, 0);
         chk($sformatf("v%0d ro_en seen", i), en, (vecs[i].win != 0) ? 1 : 0);
         repeat (5) @(negedge clk);
      end

      run4(200, lat, nv, cnt, ov);
      chk("sat latency", lat, exp_lat(211));
      chk("sat count", cnt, 15);
      chk("sat ovf", ov, 1);
      repeat (5) @(negedge clk);
      run4(4, lat, nv, cnt, ov);
      chk("post-sat latency", lat, exp_lat(15));
      chk("post-sat count", cnt, 1);
      chk("post-sat ovf", ov, 0);

      // abort 50 cycles into MEASURE
      @(negedge clk);
      window = 16'd100;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (58) @(negedge clk);
      chk("pre-abort ro_en", int'(ro_en), 1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      chk("abort ro_en", int'(ro_en), 0);
      chk("abort busy", int'(busy), 0);
      nv = 0;
      repeat (500) begin
         @(negedge clk);
         if (valid) nv++;
      end
      chk("abort nvalid", nv, 0);
      chk("abort count kept", int'(count), 10);

      // start pulsed mid-MEASURE must be ignored
      @(negedge clk);
      window = 16'd100;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      nv = 0; lat = -1;
      for (int k = 1; k <= 700; k++) begin
         @(negedge clk);
         start = (k == 50);
         if (valid) begin
            nv++;
            if (lat < 0) lat = k;
         end
      end
      start = 1'b0;
      chk("busy-start nvalid", nv, 1);
      chk("busy-start latency", lat, exp_lat(111));
      chk("busy-start count", int'(count), 10);

      // start with abort in IDLE: abort wins
      @(negedge clk);
      window = 16'd37;
      start  = 1'b1;
      abort  = 1'b1;
      @(posedge clk);
      #1 begin start = 1'b0; abort = 1'b0; end
      chk("start+abort busy", int'(busy), 0);
      nv = 0; en = 0;
      repeat (20) begin
         @(negedge clk);
         if (valid) nv++;
         if (ro_en) en = 1;
      end
      chk("start+abort nvalid", nv, 0);
      chk("start+abort ro_en", en, 0);

      // asynchronous reset mid-measurement
      @(negedge clk);
      window = 16'd100;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (30) @(negedge clk);
      chk("pre-reset ro_en", int'(ro_en), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst ro_en", int'(ro_en), 0);
      chk("async rst busy", int'(busy), 0);
      chk("async rst count", int'(count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
